// File: rtl/refresh_scheduler_pkg.sv
// Shared types, default timing values and a width helper for the refresh scheduler.
package refresh_scheduler_pkg;

   localparam int T_REFI         = 8192;
   localparam int T_RFC          = 256;
   localparam int MAXREFPOSTPONE = 8;

   typedef enum logic [1:0] {REF_IDLE, REF_REQ, REF_RFC} ref_state_t;

   // Counter width that holds 0..n-1 and never collapses to zero bits.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/refresh_scheduler_rank_timer.sv
// One rank's refresh timer: tREFI interval counter, owed-refresh count, tRFC block FSM.
// REFRESH_POSTPONE_EN allows up to MAXPOSTPONE owed refreshes; otherwise the limit is one.
module refresh_rank_timer
   import refresh_scheduler_pkg::*;
#(
   parameter int TREFI       = T_REFI,
   parameter int TRFC        = T_RFC,
   parameter int MAXPOSTPONE = MAXREFPOSTPONE,
   parameter int PHASE       = T_REFI - 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic ref_ack,
   output logic ref_req,
   output logic ref_urgent,
   output logic ref_block,
   output logic ref_overflow
);

   localparam int IW = cnt_width(TREFI);
   localparam int PW = cnt_width(MAXPOSTPONE + 1);
   localparam int RW = cnt_width(TRFC);
`ifdef REFRESH_POSTPONE_EN
   localparam int LIMIT = MAXPOSTPONE;
`else
   localparam int LIMIT = 1;
`endif

   logic [IW-1:0] icnt_q, icnt_d;
   logic [PW-1:0] pend_q, pend_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   ref_state_t    state_q, state_d;
   logic          ovf_q, ovf_d;
   logic          req_q, req_d;
   logic          urgent_q, urgent_d;
   logic          block_q, block_d;
   logic          tick, take;

   always_comb begin
      tick = en && (icnt_q == '0);
      take = (state_q == REF_REQ) && ref_ack;

      icnt_d = icnt_q;
      if (en) begin
         icnt_d = tick ? IW'(TREFI - 1) : icnt_q - IW'(1);
      end

      // A tick and an accepted REF in the same cycle cancel out, so no loss is possible.
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (tick && !take) begin
         if (pend_q == PW'(LIMIT)) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PW'(1);
         end
      end else if (take && !tick) begin
         pend_d = pend_q - PW'(1);
      end

      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         REF_IDLE: begin
            if (pend_q != '0) state_d = REF_REQ;
         end
         REF_REQ: begin
            if (ref_ack) begin
               state_d = REF_RFC;
               rcnt_d  = RW'(TRFC - 1);
            end
         end
         REF_RFC: begin
            if (rcnt_q == '0) begin
               state_d = REF_IDLE;
            end else begin
               rcnt_d = rcnt_q - RW'(1);
            end
         end
         default: state_d = REF_IDLE;
      endcase

      req_d   = (state_d == REF_REQ);
      block_d = (state_d == REF_RFC);
`ifdef REFRESH_POSTPONE_EN
      urgent_d = (state_d == REF_REQ) && (pend_d >= PW'(LIMIT));
`else
      urgent_d = (state_d == REF_REQ);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         icnt_q   <= IW'(PHASE);
         pend_q   <= '0;
         rcnt_q   <= '0;
         state_q  <= REF_IDLE;
         ovf_q    <= 1'b0;
         req_q    <= 1'b0;
         urgent_q <= 1'b0;
         block_q  <= 1'b0;
      end else begin
         icnt_q   <= icnt_d;
         pend_q   <= pend_d;
         rcnt_q   <= rcnt_d;
         state_q  <= state_d;
         ovf_q    <= ovf_d;
         req_q    <= req_d;
         urgent_q <= urgent_d;
         block_q  <= block_d;
      end
   end

   assign ref_req      = req_q;
   assign ref_urgent   = urgent_q;
   assign ref_block    = block_q;
   assign ref_overflow = ovf_q;

endmodule

// File: rtl/refresh_scheduler.sv
// Per-channel refresh scheduler: NUMRANK independent rank timers with staggered phases.
// Build with REFRESH_POSTPONE_EN defined to allow postponing up to MAXPOSTPONE refreshes.
module refresh_scheduler
   import refresh_scheduler_pkg::*;
#(
   parameter int NUMRANK     = 4,
   parameter int TREFI       = T_REFI,
   parameter int TRFC        = T_RFC,
   parameter int MAXPOSTPONE = MAXREFPOSTPONE,
   parameter int STAGGER     = TREFI / NUMRANK
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUMRANK-1:0] ref_ack,
   output logic [NUMRANK-1:0] ref_req,
   output logic [NUMRANK-1:0] ref_urgent,
   output logic [NUMRANK-1:0] ref_block,
   output logic [NUMRANK-1:0] ref_overflow
);

   // Later ranks start closer to their first tick so refreshes spread across the interval.
   for (genvar r = 0; r < NUMRANK; r++) begin : g_rank
      refresh_rank_timer #(
         .TREFI      (TREFI),
         .TRFC       (TRFC),
         .MAXPOSTPONE(MAXPOSTPONE),
         .PHASE      (TREFI - 1 - r * STAGGER)
      ) u_rank (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .ref_ack     (ref_ack[r]),
         .ref_req     (ref_req[r]),
         .ref_urgent  (ref_urgent[r]),
         .ref_block   (ref_block[r]),
         .ref_overflow(ref_overflow[r])
      );
   end

endmodule

// File: doc/refresh_scheduler.md
# refresh_scheduler

Per-channel DRAM refresh scheduler for the memory controller. It keeps one tREFI interval timer per rank and counts owed refreshes, which can be postponed. It requests a REF from each rank's RankFSM over a req/ack handshake, then holds a per-rank tRFC block so the rank scheduler does not issue commands to a refreshing rank. One instance sits beside each channel's RankFSM group.

## Interface
Parameters:
- NUMRANK, 4, ranks per channel
- TREFI, 8192 (tREFI), cycles between refresh ticks per rank
- TRFC, 256 (tRFC), cycles a rank is blocked after REF issue
- MAXPOSTPONE, 8, maximum owed refreshes per rank
- STAGGER, TREFI/NUMRANK, phase offset between rank timers

Ports:
- clk  in  1  controller clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  refresh enable (DRAM init done); timers advance only when high
- ref_ack  in  NUMRANK  RankFSM issued REF for rank r this cycle
- ref_req  out  NUMRANK  rank r owes a refresh and requests a REF slot
- ref_urgent  out  NUMRANK  rank r must refresh before any other command
- ref_block  out  NUMRANK  rank r is inside tRFC; no commands allowed
- ref_overflow  out  NUMRANK  sticky: a refresh was lost on rank r

## Operation
- Per rank: interval counter icnt[r] (width $clog2(TREFI)), pending count pend[r] (width $clog2(MAXPOSTPONE+1)), tRFC counter rcnt[r] (width $clog2(TRFC)), state in {IDLE, REQ, RFC}.
- Reset values: icnt[r] = TREFI-1 - r*STAGGER; pend = 0; rcnt = 0; state = IDLE. All outputs are 0 on reset.
- Timer: when en=1, icnt decrements each cycle. At icnt==0 it raises a tick and reloads TREFI-1. When en=0, icnt holds and no ticks occur.
- Tick increments pend, saturating at MAXPOSTPONE.
  - If pend==MAXPOSTPONE and no decrement occurs that cycle, the tick is dropped and ref_overflow[r] sets. It stays set until rst.
- FSM transitions:
  - IDLE → REQ when pend>0.
  - REQ → RFC when ref_ack[r]=1. pend decrements and rcnt loads TRFC-1.
  - RFC decrements rcnt; at rcnt==0 → IDLE.
- Simultaneous tick and ack in the same cycle: pend is unchanged, and no overflow is flagged even at MAXPOSTPONE.
- ref_ack[r] outside REQ is ignored (no pend change, no state change).
- en dropping mid-RFC: the RFC period completes normally, and an outstanding REQ stays asserted.
- Outputs are decoded from registered state only:
  - ref_req[r] = (state==REQ)
  - ref_block[r] = (state==RFC)
  - ref_urgent[r] = (state==REQ) && (pend ≥ MAXPOSTPONE)
- Ranks are fully independent; the block does no cross-rank arbitration. Command-bus arbitration belongs to the RankFSM/channel scheduler.

## Timing
- Tick at cycle t → pend=1 at t+1 → state REQ, ref_req=1 at t+2.
- ref_req stays high until ack; there is no timeout.
- Ack sampled at cycle a → ref_req=0 and ref_block=1 from a+1 through a+TRFC (exactly TRFC cycles) → IDLE at a+TRFC+1.
  - If pend>0 remains, ref_req rises again at a+TRFC+2.
- First tick on rank r occurs TREFI - r*STAGGER cycles after en first goes high from reset.
- Minimum REQ duration is 1 cycle (ack in the first REQ cycle is legal).

## Configuration
- REFRESH_POSTPONE_EN defined: behaviour as above; up to MAXPOSTPONE refreshes may be owed.
  - ref_urgent asserts only when pend reaches MAXPOSTPONE.
- Undefined: the effective postpone limit is 1, and MAXPOSTPONE is ignored.
  - ref_urgent equals ref_req.
  - A tick while pend==1 with no same-cycle ack sets ref_overflow.

## Structure
- Shared package gets MAXREFPOSTPONE = 8 and typedef enum logic [1:0] {REF_IDLE, REF_REQ, REF_RFC} ref_state_t.
  - Existing tREFI and tRFC serve as parameter defaults.
- Sub-module refresh_rank_timer holds one rank's icnt/pend/rcnt/FSM. It is instantiated NUMRANK times in a generate loop, with its reset phase passed as a parameter.

## Test plan
Benches run with TREFI=64, TRFC=8, NUMRANK=4, MAXPOSTPONE=8.
- Reset then en=1 at cycle 0, ack immediately on each req → rank0 ref_req at cycle 65; rank1 at cycle 49, rank2 at 33, rank3 at 17. Each ref_block lasts exactly 8 cycles.
- No ack on rank0 for 8×64 cycles (macro on) → ref_urgent[0] rises when pend reaches 8; a 9th tick sets ref_overflow[0]. Then 8 acks → pend returns to 0, overflow stays 1.
- Ack asserted on the same cycle as a tick with pend=8 → pend stays 8, ref_overflow stays 0.
- Spurious ref_ack[2] while rank2 is IDLE or RFC → no state change, no extra ref_block cycles.
- Assert rst mid-RFC on rank1 → all outputs 0 immediately. After release, icnt[1] restarts at 47.
- Macro off: rank0 unacked through two ticks → ref_urgent[0]==ref_req[0] throughout; ref_overflow[0] sets on the second tick.
